// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the UDP-payload video unpacker.
package udp_rx_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    PIX  = 2'd1,
    TAIL = 2'd2
  } rx_state_t;

  localparam logic [31:0] DEF_FRAME_HEAD = 32'hF3ED7A93;
  localparam logic [31:0] DEF_FRAME_TAIL = 32'hF3ED7A94;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/udp_pix_pack.sv
// Packs PIX_BYTES payload bytes big-endian into one pixel; pix_valid is combinational on the last byte.
module udp_pix_pack #(
  parameter int PIX_BYTES = 2,
  parameter int DATA_W    = 8 * PIX_BYTES
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              byte_vld,
  input  logic [7:0]        byte_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid
);

  localparam logic [1:0] CNT_LAST = 2'(PIX_BYTES - 1);

  logic [1:0] cnt;

  assign pix_valid = byte_vld && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rstn || clr)  cnt <= 2'd0;
    else if (byte_vld) cnt <= pix_valid ? 2'd0 : cnt + 2'd1;
  end

  generate
    if (PIX_BYTES == 1) begin : g_one
      assign pix_data = byte_data;
    end else begin : g_multi
      // Stale bytes left by a dropped pixel are shifted out before the next pixel completes.
      logic [DATA_W-9:0] sr;
      always_ff @(posedge clk) begin
        if (byte_vld) sr <= pix_data[DATA_W-9:0];
      end
      assign pix_data = {sr, byte_data};
    end
  endgenerate

endmodule

// File: rtl/udp_rx_vid_unpack.sv
// UDP payload to video unpacker: head hunt, pixel packing, geometry flags, tail check.
// Optional stall timeout enabled by defining UDP_RX_VID_TIMEOUT_EN.
module udp_rx_vid_unpack
  import udp_rx_pkg::*;
#(
  parameter int          PIX_BYTES   = 2,
  parameter int          H_ACTIVE    = 640,
  parameter int          V_ACTIVE    = 480,
  parameter logic [31:0] FRAME_HEAD  = DEF_FRAME_HEAD,
  parameter logic [31:0] FRAME_TAIL  = DEF_FRAME_TAIL,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic                   app_rx_clk,
  input  logic                   rstn,
  input  logic                   app_rx_data_valid,
  input  logic [7:0]             app_rx_data,
  output logic                   vid_clk,
  output logic                   vid_vs,
  output logic                   vid_de,
  output logic                   vid_eol,
  output logic [8*PIX_BYTES-1:0] vid_data,
  output logic                   frame_ok,
  output logic                   frame_err
);

  localparam int DATA_W = 8 * PIX_BYTES;
  localparam int COL_W  = clog2_min1(H_ACTIVE);
  localparam int ROW_W  = clog2_min1(V_ACTIVE);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);

  rx_state_t         state_q, state_d;
  // Only the three newest bytes are stored; the fourth is the live input byte.
  logic [23:0]       hdr_q, hdr_d;
  logic [31:0]       hdr_next;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [1:0]        tail_cnt_q, tail_cnt_d;
  logic              vs_d, de_d, eol_d, ok_d, err_d;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              timeout_hit;

  assign vid_clk  = app_rx_clk;
  assign hdr_next = {hdr_q, app_rx_data};

  udp_pix_pack #(.PIX_BYTES(PIX_BYTES), .DATA_W(DATA_W)) u_pack (
    .clk       (app_rx_clk),
    .rstn      (rstn),
    .clr       ((state_q != PIX) || timeout_hit),
    .byte_vld  (app_rx_data_valid && (state_q == PIX)),
    .byte_data (app_rx_data),
    .pix_data  (pix_data),
    .pix_valid (pix_valid)
  );

`ifdef UDP_RX_VID_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_q;

  assign timeout_hit = (state_q != HUNT) && !app_rx_data_valid &&
                       (stall_q == STALL_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge app_rx_clk) begin
    if (!rstn || app_rx_data_valid || (state_q == HUNT) || timeout_hit) stall_q <= '0;
    else                                                              stall_q <= stall_q + 1'b1;
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    col_d      = col_q;
    row_d      = row_q;
    tail_cnt_d = tail_cnt_q;
    vs_d       = 1'b0;
    de_d       = 1'b0;
    eol_d      = 1'b0;
    data_d     = '0;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      HUNT: begin
        if (app_rx_data_valid) begin
          hdr_d = hdr_next[23:0];
          if (hdr_next == FRAME_HEAD) begin
            state_d = PIX;
            vs_d    = 1'b1;
            col_d   = '0;
            row_d   = '0;
          end
        end
      end
      PIX: begin
        if (pix_valid) begin
          de_d   = 1'b1;
          data_d = pix_data;
          if (col_q == COL_LAST) begin
            col_d = '0;
            eol_d = 1'b1;
            if (row_q == ROW_LAST) begin
              state_d    = TAIL;
              hdr_d      = '0;
              tail_cnt_d = 2'd0;
              row_d      = '0;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      TAIL: begin
        if (app_rx_data_valid) begin
          hdr_d      = hdr_next[23:0];
          tail_cnt_d = tail_cnt_q + 2'd1;
          if (tail_cnt_q == 2'd3) begin
            // Clearing hdr stops tail bytes from ever completing a head.
            state_d    = HUNT;
            hdr_d      = '0;
            tail_cnt_d = 2'd0;
            ok_d       = (hdr_next == FRAME_TAIL);
            err_d      = (hdr_next != FRAME_TAIL);
          end
        end
      end
      default: state_d = HUNT;
    endcase
    if (timeout_hit) begin
      state_d    = HUNT;
      hdr_d      = '0;
      tail_cnt_d = 2'd0;
      err_d      = 1'b1;
    end
  end

  always_ff @(posedge app_rx_clk) begin
    if (!rstn) begin
      state_q    <= HUNT;
      hdr_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      tail_cnt_q <= 2'd0;
      vid_vs     <= 1'b0;
      vid_de     <= 1'b0;
      vid_eol    <= 1'b0;
      vid_data   <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      tail_cnt_q <= tail_cnt_d;
      vid_vs     <= vs_d;
      vid_de     <= de_d;
      vid_eol    <= eol_d;
      vid_data   <= data_d;
      frame_ok   <= ok_d;
      frame_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_udp_rx_vid_unpack.sv
// Randomised bench for udp_rx_vid_unpack: a stream-level model predicts every output event and its cycle.
module tb_udp_rx_vid_unpack;

  localparam int PB   = 2;
  localparam int H    = 4;
  localparam int V    = 2;
  localparam int TO   = 16;
  localparam int NPIX = H * V;
  localparam logic [31:0] HEAD = 32'hF3ED7A93;
  localparam logic [31:0] TAIL = 32'hF3ED7A94;
`ifdef UDP_RX_VID_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        app_rx_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        app_rx_data_valid = 1'b0;
  logic [7:0]  app_rx_data = 8'd0;
  logic        vid_clk, vid_vs, vid_de, vid_eol, frame_ok, frame_err;
  logic [15:0] vid_data;

  udp_rx_vid_unpack #(
    .PIX_BYTES(PB), .H_ACTIVE(H), .V_ACTIVE(V), .TIMEOUT_CYC(TO)
  ) dut (
    .app_rx_clk        (app_rx_clk),
    .rstn              (rstn),
    .app_rx_data_valid (app_rx_data_valid),
    .app_rx_data       (app_rx_data),
    .vid_clk           (vid_clk),
    .vid_vs            (vid_vs),
    .vid_de            (vid_de),
    .vid_eol           (vid_eol),
    .vid_data          (vid_data),
    .frame_ok          (frame_ok),
    .frame_err         (frame_err)
  );

  always #4 app_rx_clk = ~app_rx_clk;

  int cyc = 0;
  always @(posedge app_rx_clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          log_en   = 1'b0;
  logic [63:0] act_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  bv[$];
  int          bc[$];
  logic [7:0]  pix_buf[16];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mk_ev(int c, bit vs, bit de, bit eol, bit ok, bit err,
                                        logic [15:0] d);
    return {11'd0, c, vs, de, eol, ok, err, d};
  endfunction

  always @(negedge app_rx_clk) begin
    if (log_en && (vid_vs || vid_de || vid_eol || frame_ok || frame_err || (vid_data != 16'd0)))
      act_q.push_back(mk_ev(cyc, vid_vs, vid_de, vid_eol, frame_ok, frame_err, vid_data));
  end

  task automatic tick();
    @(negedge app_rx_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      app_rx_data_valid = 1'b0;
      app_rx_data       = 8'($urandom);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gmin, input int gmax);
    idle(int'($urandom_range(gmax, gmin)));
    tick();
    app_rx_data_valid = 1'b1;
    app_rx_data       = b;
    bv.push_back(b);
    bc.push_back(cyc);
  endtask

  task automatic send_word(input logic [31:0] w, input int gmin, input int gmax);
    for (int i = 0; i < 4; i++) send(w[31-8*i -: 8], gmin, gmax);
  endtask

  task automatic send_frame(input logic [31:0] tl, input int gmin, input int gmax);
    send_word(HEAD, gmin, gmax);
    for (int i = 0; i < 16; i++) send(pix_buf[i], gmin, gmax);
    send_word(tl, gmin, gmax);
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 16; i++) pix_buf[i] = 8'(i);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) pix_buf[i] = 8'($urandom);
  endtask

  // Next byte for an open frame: abort on end of stream or on a stall long enough to time out.
  task automatic consume(input int k, input int prev, input int seg_end, output bit ab);
    ab = 1'b0;
    if (k >= bv.size()) begin
      ab = 1'b1;
      if (TO_EN && (prev + TO + 1 <= seg_end)) exp_q.push_back(mk_ev(prev + TO + 1, 0, 0, 0, 0, 1, 16'd0));
    end else if (TO_EN && (bc[k] - prev - 1 >= TO)) begin
      ab = 1'b1;
      exp_q.push_back(mk_ev(prev + TO + 1, 0, 0, 0, 0, 1, 16'd0));
    end
  endtask

  task automatic run_model(input int seg_end);
    int i, j, k, prev, n;
    bit ab;
    logic [15:0] px;
    logic [31:0] tw;
    i = 0;
    n = bv.size();
    while (i < n) begin
      j = -1;
      for (int s = i; (s + 3 < n) && (j < 0); s++)
        if ({bv[s], bv[s+1], bv[s+2], bv[s+3]} == HEAD) j = s + 3;
      if (j < 0) break;
      exp_q.push_back(mk_ev(bc[j] + 1, 1, 0, 0, 0, 0, 16'd0));
      k = j + 1;
      prev = bc[j];
      ab = 1'b0;
      for (int p = 0; (p < NPIX) && !ab; p++) begin
        px = 16'd0;
        for (int b = 0; (b < PB) && !ab; b++) begin
          consume(k, prev, seg_end, ab);
          if (!ab) begin px = {px[7:0], bv[k]}; prev = bc[k]; k++; end
        end
        if (!ab) exp_q.push_back(mk_ev(prev + 1, 0, 1, (p % H) == H - 1, 0, 0, px));
      end
      tw = 32'd0;
      for (int t = 0; (t < 4) && !ab; t++) begin
        consume(k, prev, seg_end, ab);
        if (!ab) begin tw = {tw[23:0], bv[k]}; prev = bc[k]; k++; end
      end
      if (!ab) exp_q.push_back(mk_ev(prev + 1, 0, 0, 0, tw == TAIL, tw != TAIL, 16'd0));
      i = k;
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, ".n_events"}, 64'(act_q.size()), 64'(exp_q.size()));
    for (int e = 0; (e < act_q.size()) && (e < exp_q.size()); e++)
      chk({tag, ".event"}, act_q[e], exp_q[e]);
    act_q.delete();
    exp_q.delete();
    bv.delete();
    bc.delete();
  endtask

  task automatic end_seg(input string tag);
    idle(40);
    run_model(cyc);
    compare(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    idle(4);
    chk("reset_outputs", 64'({vid_vs, vid_de, vid_eol, frame_ok, frame_err, vid_data}), 64'd0);
    chk("vid_clk", 64'(vid_clk), 64'(app_rx_clk));
    rstn   = 1'b1;
    log_en = 1'b1;
    idle(2);

    fill_seq();
    send_frame(TAIL, 0, 0);
    end_seg("nominal");

    send_frame(TAIL, 3, 3);
    end_seg("gappy");

    fill_seq();
    pix_buf[4] = 8'hF3; pix_buf[5] = 8'hED; pix_buf[6] = 8'h7A; pix_buf[7] = 8'h93;
    send_frame(TAIL, 0, 1);
    end_seg("embedded_head");

    fill_rand();
    send_frame(32'hF3ED7A95, 0, 0);
    fill_rand();
    send_frame(TAIL, 0, 2);
    end_seg("bad_tail");

    fill_seq();
    send_word(HEAD, 0, 0);
    for (int i = 0; i < 5; i++) send(pix_buf[i], 0, 0);
    tick();
    app_rx_data_valid = 1'b0;
    rstn = 1'b0;
    run_model(cyc);
    compare("pre_reset");
    tick();
    chk("mid_reset_outputs", 64'({vid_vs, vid_de, vid_eol, frame_ok, frame_err, vid_data}), 64'd0);
    rstn = 1'b1;
    send(8'h11, 0, 0);
    send(8'h22, 0, 0);
    send_frame(TAIL, 0, 0);
    end_seg("post_reset");

    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(3, 0)) send(8'($urandom), 0, 2);
      fill_rand();
      send_frame(($urandom_range(1, 0) == 0) ? TAIL : 32'($urandom), 0, 2);
      end_seg("random");
    end

    if (TO_EN) begin
      send_word(HEAD, 0, 0);
      for (int i = 0; i < 3; i++) send(8'($urandom), 0, 0);
      end_seg("timeout_pix");
      fill_rand();
      send_frame(TAIL, 0, 1);
      end_seg("after_timeout");
      send_word(HEAD, 0, 0);
      for (int i = 0; i < 16; i++) send(8'($urandom), 0, 0);
      send(8'hF3, 0, 0);
      send(8'hED, 0, 0);
      end_seg("timeout_tail");
      fill_rand();
      send_frame(TAIL, 0, 0);
      end_seg("after_tail_timeout");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
